// File: rtl/io_timer_pkg.sv
// rtl/io_timer_pkg.sv - register map offsets and field indices for the IO timer controller
package io_timer_pkg;

    localparam int DATA_W  = 32;
    localparam int NCH_MAX = 6;

    localparam int ADDR_CTRL    = 0;
    localparam int ADDR_PRESC   = 1;
    localparam int ADDR_PEND    = 2;
    localparam int ADDR_IRQEN   = 3;
    localparam int ADDR_CH_BASE = 4;

    localparam int CTRL_EN      = 0;
    localparam int CFG_EN       = 0;
    localparam int CFG_PERIODIC = 1;

    // Channel i owns a CFG/PERIOD register pair starting at ADDR_CH_BASE
    function automatic int ch_cfg_addr(input int ch);
        return ADDR_CH_BASE + 2 * ch;
    endfunction

    function automatic int ch_period_addr(input int ch);
        return ADDR_CH_BASE + 2 * ch + 1;
    endfunction

endpackage

// File: rtl/io_timer_tick_prescaler.sv
// rtl/io_timer_tick_prescaler.sv - shared base-tick generator, one tick every reload+1 cycles
module tick_prescaler #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] reload,
    input  logic         clr,
    output logic         tick
);

    logic [W-1:0] cnt;

    // A clear restarts the phase and swallows a tick that would have fired this cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (!en || clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == reload) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/io_timer_ctrl.sv
// rtl/io_timer_ctrl.sv - multi-channel timer controller with sticky pending flags
// Optional interrupt logic (IRQEN register, irq output) built when TIMER_IRQ_EN is defined.
module io_timer_ctrl
    import io_timer_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int PRESC_W = 16,
    parameter int CNT_W   = 16,
    parameter int ADDR_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              tick,
    output logic              irq
);

    logic               wr;
    logic               rd;
    logic               wr_ctrl;
    logic               wr_presc;
    logic               wr_pend;
    logic               ctrl_en;
    logic [PRESC_W-1:0] presc;
    logic [NCH-1:0]     pend;
    logic [NCH-1:0]     pend_set;
    logic [NCH-1:0]     pend_clr;
    logic [NCH-1:0]     irqen;
    logic [NCH-1:0]     cfg_en;
    logic [NCH-1:0]     cfg_per;
    logic [CNT_W-1:0]   period_v [NCH];
    logic [DATA_W-1:0]  rd_mux;
    logic               unused_wdata;

    assign wr       = sel & we;
    assign rd       = sel & ~we;
    assign wr_ctrl  = wr && (int'(addr) == ADDR_CTRL);
    assign wr_presc = wr && (int'(addr) == ADDR_PRESC);
    assign wr_pend  = wr && (int'(addr) == ADDR_PEND);
    assign pend_clr = wr_pend ? wdata[NCH-1:0] : '0;

    assign unused_wdata = ^wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_en <= 1'b0;
            presc   <= '0;
        end else begin
            if (wr_ctrl)
                ctrl_en <= wdata[CTRL_EN];
            if (wr_presc)
                presc <= wdata[PRESC_W-1:0];
        end
    end

    tick_prescaler #(
        .W (PRESC_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .en     (ctrl_en),
        .reload (presc),
        .clr    (wr_presc),
        .tick   (tick)
    );

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic             wr_cfg;
        logic             wr_period;
        logic             load;
        logic             expire;
        logic             en_q;
        logic             per_q;
        logic [CNT_W-1:0] period_q;
        logic [CNT_W-1:0] ccnt;

        assign wr_cfg    = wr && (int'(addr) == ch_cfg_addr(i));
        assign wr_period = wr && (int'(addr) == ch_period_addr(i));
        assign load      = wr_cfg && wdata[CFG_EN] && !en_q;
        assign expire    = tick && en_q && (ccnt == '0);

        // CPU writes to CFG take precedence over the one-shot self-disable
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                en_q     <= 1'b0;
                per_q    <= 1'b0;
                period_q <= '0;
                ccnt     <= '0;
            end else begin
                if (wr_cfg) begin
                    en_q  <= wdata[CFG_EN];
                    per_q <= wdata[CFG_PERIODIC];
                end else if (expire && !per_q) begin
                    en_q <= 1'b0;
                end

                if (wr_period)
                    period_q <= wdata[CNT_W-1:0];

                if (load) begin
                    ccnt <= period_q;
                end else if (tick && en_q) begin
                    if (ccnt == '0) begin
                        if (per_q)
                            ccnt <= period_q;
                    end else begin
                        ccnt <= ccnt - 1'b1;
                    end
                end
            end
        end

        assign cfg_en[i]   = en_q;
        assign cfg_per[i]  = per_q;
        assign period_v[i] = period_q;
        assign pend_set[i] = expire;
    end

    // Set beats clear so an expiry coinciding with W1C is never lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pend <= '0;
        else
            pend <= (pend & ~pend_clr) | pend_set;
    end

`ifdef TIMER_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irqen <= '0;
            irq_q <= 1'b0;
        end else begin
            if (wr && (int'(addr) == ADDR_IRQEN))
                irqen <= wdata[NCH-1:0];
            irq_q <= |(pend & irqen);
        end
    end

    assign irq = irq_q;
`else
    assign irqen = '0;
    assign irq   = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        if (int'(addr) == ADDR_CTRL)
            rd_mux[CTRL_EN] = ctrl_en;
        if (int'(addr) == ADDR_PRESC)
            rd_mux[PRESC_W-1:0] = presc;
        if (int'(addr) == ADDR_PEND)
            rd_mux[NCH-1:0] = pend;
        if (int'(addr) == ADDR_IRQEN)
            rd_mux[NCH-1:0] = irqen;
        for (int i = 0; i < NCH; i++) begin
            if (int'(addr) == ch_cfg_addr(i)) begin
                rd_mux[CFG_EN]       = cfg_en[i];
                rd_mux[CFG_PERIODIC] = cfg_per[i];
            end
            if (int'(addr) == ch_period_addr(i))
                rd_mux[CNT_W-1:0] = period_v[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd;
            if (rd)
                rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_io_timer_ctrl.sv
// tb/tb_io_timer_ctrl.sv - self-checking bench for io_timer_ctrl (vectors, corner sequences, random vs model)
module tb_io_timer_ctrl;

    localparam int NCH = 4;
`ifdef TIMER_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        tick;
    logic        irq;

    int tests  = 0;
    int failed = 0;
    logic [31:0] last_rdata;

    always #5 clk = ~clk;

    io_timer_ctrl #(
        .NCH     (NCH),
        .PRESC_W (16),
        .CNT_W   (16),
        .ADDR_W  (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sel    (sel),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .rvalid (rvalid),
        .tick   (tick),
        .irq    (irq)
    );

    // Reference model: prescaler phase as elapsed-cycles modulo period, channels as ticks-left
    bit           m_en;
    int           m_presc;
    int           m_age;
    bit           m_tick;
    bit           m_irq;
    bit           m_rv;
    logic [31:0]  m_rd;
    bit [NCH-1:0] m_pend;
    bit [NCH-1:0] m_irqen;
    bit           m_run    [NCH];
    bit           m_perd   [NCH];
    int           m_period [NCH];
    int           m_left   [NCH];

    task automatic m_reset();
        m_en = 0; m_presc = 0; m_age = 0; m_tick = 0; m_irq = 0; m_rv = 0; m_rd = 0;
        m_pend = '0; m_irqen = '0;
        for (int i = 0; i < NCH; i++) begin
            m_run[i] = 0; m_perd[i] = 0; m_period[i] = 0; m_left[i] = 0;
        end
    endtask

    function automatic logic [31:0] m_reg(input int a);
        if (a == 0) return {31'd0, m_en};
        if (a == 1) return m_presc;
        if (a == 2) return {{(32-NCH){1'b0}}, m_pend};
        if (a == 3) return IRQ_ON ? {{(32-NCH){1'b0}}, m_irqen} : 32'd0;
        if (a >= 4 && a < 4 + 2 * NCH) begin
            if ((a - 4) % 2 == 0) return {30'd0, m_perd[(a-4)/2], m_run[(a-4)/2]};
            return m_period[(a-4)/2];
        end
        return 32'd0;
    endfunction

    task automatic m_step(input bit s, input bit w, input int a, input logic [31:0] d);
        bit [NCH-1:0] set;
        bit           old_run [NCH];
        bit           pw;
        bit           nt;
        bit           ni;
        set = '0;
        pw  = s && w && (a == 1);
        m_rv = s && !w;
        if (m_rv) m_rd = m_reg(a);
        nt = m_en && !pw && ((m_age % (m_presc + 1)) == m_presc);
        m_age = (!m_en || pw) ? 0 : m_age + 1;
        ni = IRQ_ON && (|(m_pend & m_irqen));
        for (int i = 0; i < NCH; i++) begin
            old_run[i] = m_run[i];
            if (m_tick && m_run[i]) begin
                if (m_left[i] == 0) begin
                    set[i] = 1'b1;
                    if (m_perd[i]) m_left[i] = m_period[i];
                    else           m_run[i]  = 1'b0;
                end else begin
                    m_left[i] = m_left[i] - 1;
                end
            end
        end
        if (s && w) begin
            if (a == 0) m_en = d[0];
            if (a == 1) m_presc = int'(d[15:0]);
            if (a == 2) m_pend = m_pend & ~d[NCH-1:0];
            if (a == 3 && IRQ_ON) m_irqen = d[NCH-1:0];
            for (int i = 0; i < NCH; i++) begin
                if (a == 4 + 2 * i) begin
                    if (d[0] && !old_run[i]) m_left[i] = m_period[i];
                    m_run[i]  = d[0];
                    m_perd[i] = d[1];
                end
                if (a == 5 + 2 * i) m_period[i] = int'(d[15:0]);
            end
        end
        m_pend = m_pend | set;
        m_irq  = ni;
        m_tick = nt;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One bus cycle: drive, clock, advance the model, compare outputs 1 time unit after the edge
    task automatic cyc(input bit s, input bit w, input int a, input logic [31:0] d);
        sel = s; we = w; addr = a[3:0]; wdata = d;
        @(posedge clk);
        m_step(s, w, a, d);
        #1;
        chk("tick", {31'd0, tick}, {31'd0, m_tick});
        chk("irq", {31'd0, irq}, {31'd0, m_irq});
        chk("rvalid", {31'd0, rvalid}, {31'd0, m_rv});
        if (m_rv) chk("rdata_model", rdata, m_rd);
        last_rdata = rdata;
        sel = 0; we = 0;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        cyc(1, 1, a, d);
    endtask

    task automatic rd(input int a);
        cyc(1, 0, a, 32'd0);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 32'd0);
    endtask

    task automatic do_reset();
        #3 rst = 1'b1;
        #1;
        m_reset();
        chk("rst_tick", {31'd0, tick}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        bit          w;
        int          a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input bit w, input int a, input logic [31:0] d, input logic [31:0] exp);
        vec_t v;
        v.w = w; v.a = a; v.d = d; v.exp = exp;
        return v;
    endfunction

    initial begin
        int          tk[$];
        int          k;
        int          r;
        int          a;
        logic [31:0] d;

        rst = 1'b1; sel = 0; we = 0; addr = 0; wdata = 0;
        m_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Register read/write vectors with the timer disabled
        tbl.push_back(mk(0, 0,  0, 32'h0));
        tbl.push_back(mk(0, 2,  0, 32'h0));
        tbl.push_back(mk(1, 1,  32'hABCD1234, 0));
        tbl.push_back(mk(0, 1,  0, 32'h1234));
        tbl.push_back(mk(1, 4,  32'hFFFFFFFE, 0));
        tbl.push_back(mk(0, 4,  0, 32'h2));
        tbl.push_back(mk(1, 5,  32'h12345678, 0));
        tbl.push_back(mk(0, 5,  0, 32'h5678));
        tbl.push_back(mk(1, 11, 32'h0001FFFF, 0));
        tbl.push_back(mk(0, 11, 0, 32'hFFFF));
        tbl.push_back(mk(1, 12, 32'hFFFFFFFF, 0));
        tbl.push_back(mk(0, 12, 0, 32'h0));
        tbl.push_back(mk(0, 15, 0, 32'h0));
        tbl.push_back(mk(1, 3,  32'h000000FF, 0));
        tbl.push_back(mk(0, 3,  0, IRQ_ON ? 32'hF : 32'h0));
        tbl.push_back(mk(1, 0,  32'hFFFFFFFE, 0));
        tbl.push_back(mk(0, 0,  0, 32'h0));
        tbl.push_back(mk(1, 2,  32'h0000000F, 0));
        tbl.push_back(mk(0, 2,  0, 32'h0));
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].w) wr(tbl[i].a, tbl[i].d);
            else begin
                rd(tbl[i].a);
                chk($sformatf("vec%0d_addr%0d", i, tbl[i].a), last_rdata, tbl[i].exp);
            end
        end
        do_reset();

        // Prescaler period 4, first tick 4 cycles after enable
        wr(1, 3);
        wr(0, 1);
        for (int n = 1; n <= 20; n++) begin
            idle();
            if (tick) tk.push_back(n);
        end
        chk("tick_count", tk.size(), 5);
        if (tk.size() >= 3) begin
            chk("tick_first", tk[0], 4);
            chk("tick_gap0", tk[1] - tk[0], 4);
            chk("tick_gap1", tk[2] - tk[1], 4);
        end

        // PRESC rewrite mid-count restarts the phase
        k = 0;
        while (!tick && k < 8) begin idle(); k++; end
        chk("tick_align", {31'd0, tick}, 32'd1);
        idle();
        idle();
        wr(1, 3);
        k = 0;
        do begin idle(); k++; end while (!tick && k < 10);
        chk("presc_rewrite_delay", k, 4);

        // Periodic channel 0 at one tick per cycle, W1C racing expiry
        wr(1, 0);
        wr(5, 2);
        wr(4, 3);
        rd(2); chk("p0_c1", last_rdata & 1, 0);
        rd(2); chk("p0_c2", last_rdata & 1, 0);
        rd(2); chk("p0_c3", last_rdata & 1, 0);
        rd(2); chk("p0_c4", last_rdata & 1, 1);
        rd(2); chk("p0_c5", last_rdata & 1, 1);
        wr(2, 1);
        rd(2); chk("w1c_on_expiry", last_rdata & 1, 1);
        wr(2, 1);
        rd(2); chk("w1c_clear", last_rdata & 1, 0);
        rd(2); chk("p0_repeat", last_rdata & 1, 1);

        // One-shot channel 1
        wr(7, 0);
        wr(6, 1);
        rd(2); chk("os_before", last_rdata & 2, 0);
        rd(2); chk("os_fired", last_rdata & 2, 2);
        rd(6); chk("os_cfg_cleared", last_rdata, 0);
        wr(2, 2);
        for (int n = 0; n < 4; n++) begin
            rd(2); chk("os_no_refire", last_rdata & 2, 0);
        end

        // All channels pending, then asynchronous reset mid-count
        wr(6, 3);
        wr(8, 3);
        wr(10, 3);
        idle(); idle(); idle();
        rd(2); chk("pend_all", last_rdata, 32'hF);
        do_reset();
        for (int i = 0; i < 12; i++) begin
            rd(i);
            chk($sformatf("post_rst_addr%0d", i), last_rdata, 0);
        end

        // Randomised traffic against the model
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 9);
            a = $urandom_range(0, 15);
            d = $urandom;
            if (r < 4) idle();
            else if (r < 7) rd(a);
            else begin
                if (a == 0) d[0] = ($urandom_range(0, 3) != 0);
                if (a == 1) d[15:0] = 16'($urandom_range(0, 3));
                if (a >= 5 && a % 2 == 1) d[15:0] = 16'($urandom_range(0, 6));
                wr(a, d);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
